seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE, default 2, is the number of consecutive identical samples needed to accept a digit (legal range 1..15).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 seg  input  7  active-high segment lines: bit0=a through bit5=f, bit6=g.
REQ-005 dig_en  input  4  active-high digit strobe; bit n selects hex digit n, where digit 0 is value[3:0].
REQ-006 value  output  16  last complete captured frame.
REQ-007 valid  output  1  one-cycle pulse when value updates.
REQ-008 err  output  1  one-cycle pulse on any protocol or pattern error.

Function
REQ-009 The block SHALL convert a scanned four-digit 7-seg bus back into a 16-bit value, inverting the team's hex segment table.
- Table: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-010 Sampling SHALL be registered: seg and dig_en are sampled every cycle, and the decision logic acts on the sampled values.
REQ-011 dig_en==0000 SHALL be a blanking cycle.
- It is ignored and neither advances nor breaks a stability run.
REQ-012 dig_en with more than one bit set SHALL pulse err and return the FSM to SYNC.
REQ-013 A "visit" SHALL be the run of cycles, blanking excluded, in which dig_en holds the same one-hot code; a new visit begins when the code changes.
REQ-014 Within a visit, the digit SHALL be accepted on the STABLE-th consecutive identical legal sample.
- A changed pattern restarts the count at 1.
- Samples after acceptance in the same visit are ignored.
REQ-015 A seg pattern not in the table, sampled during an unaccepted visit, SHALL pulse err and return the FSM to SYNC.
REQ-016 FSM states SHALL be SYNC and COLLECT, with a 2-bit expected-digit index.
REQ-017 In SYNC, visits other than digit 0 SHALL be ignored silently.
- Acceptance of digit 0 stores its nibble in a shadow register, sets expected=1 and enters COLLECT.
REQ-018 In COLLECT, a visit to the expected digit SHALL be processed per REQ-014; acceptance stores the nibble and increments expected.
REQ-019 In COLLECT, a visit to any digit other than the expected digit SHALL pulse err and enter SYNC.
- The same applies when a visit ends without acceptance.
- The shadow register is discarded.
REQ-020 On acceptance of digit 3, the block SHALL:
- load value from the shadow register, including the digit-3 nibble, on the next edge;
- pulse valid in that same cycle;
- enter SYNC.
REQ-021 Latency from the sampled STABLE-th digit-3 sample to valid SHALL be exactly 1 cycle, i.e. 2 cycles from the input pins.
REQ-022 If an error and a completion occur in the same cycle, err SHALL take priority: no valid pulse and value unchanged.
REQ-023 value SHALL hold between frames; a failed frame SHALL never alter value.

Reset
REQ-024 While reset is high at a clk edge, the block SHALL set:
- value=16'h0000, valid=0, err=0;
- state=SYNC, expected=0;
- stability counter and shadow register cleared;
- sampled registers cleared.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no valid or err pulse.
- The first frame accepted after reset must begin with digit 0.

Structure
REQ-026 A shared package/include SHALL hold:
- the 16 segment pattern constants;
- the FSM state encodings;
- the STABLE default.
REQ-027 A combinational sub-module seg7_to_hex SHALL map seg[6:0] to {legal, nibble[3:0]}.
- seg7_to_hex is reusable by other display blocks.

Verification
REQ-028 With STABLE=2, scan digits 0..3 with patterns F, 2, A, 1, two cycles each -> one valid pulse and value=16'h1A2F.
REQ-029 Same frame with one blank (0000) cycle between and within each visit -> value=16'h1A2F; err never asserted.
REQ-030 Digit 2 visit shows 1110111 then 1111001, one cycle each -> err pulse, no valid, value keeps its previous contents.
REQ-031 Illegal pattern 0000001 on digit 1 -> err pulse, FSM in SYNC; the next clean frame 0x0000 decodes correctly.
REQ-032 dig_en=0101 mid-frame -> err; scan order 0,2,... -> err at the digit-2 visit.
REQ-033 Reset asserted after digit 2 is accepted -> no pulses, value=0; a subsequent full frame 0xBEEF -> value=16'hBEEF.

Source files
------------

// File: rtl/seg_scan_decoder_pkg.sv
// Shared definitions for the scanned 7-segment decoder: hex segment table,
// FSM states and the default stability count.
package seg_scan_decoder_pkg;

   localparam int unsigned STABLE_DEFAULT = 2;

   // Index is the hex value; bit0=a .. bit5=f, bit6=g.
   localparam logic [6:0] SEG_HEX [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

   typedef enum logic {
      SYNC    = 1'b0,
      COLLECT = 1'b1
   } state_t;

endpackage

// File: rtl/seg_scan_decoder_seg7_to_hex.sv
// Combinational inverse of the hex segment table; legal is low for any
// pattern that is not one of the 16 digit glyphs.
module seg7_to_hex
   import seg_scan_decoder_pkg::*;
(
   input  logic [6:0] seg,
   output logic       legal,
   output logic [3:0] nibble
);

   always_comb begin
      legal  = 1'b0;
      nibble = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (seg == SEG_HEX[4'(i)]) begin
            legal  = 1'b1;
            nibble = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers a 16-bit value from a scanned four-digit 7-segment bus. Digits
// must arrive in order 0..3, each held stable for STABLE samples.
module seg_scan_decoder
   import seg_scan_decoder_pkg::*;
#(
   parameter int unsigned STABLE = STABLE_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  seg,
   input  logic [3:0]  dig_en,
   output logic [15:0] value,
   output logic        valid,
   output logic        err
);

   localparam logic [3:0] STABLE_CNT = 4'(STABLE);

   logic [6:0]  seg_q;
   logic [3:0]  en_q;
   state_t      state;
   logic [1:0]  expected;
   logic [3:0]  cnt;
   logic [6:0]  last_seg;
   logic [3:0]  cur_en;
   logic        done;
   logic [11:0] shadow;

   logic        legal;
   logic [3:0]  nibble;
   logic        onehot;
   logic        multi;
   logic [1:0]  idx;
   logic        new_visit;
   logic        track;
   logic        visit_fail;
   logic        live;
   logic        fail;
   logic        accept;
   logic [3:0]  run;

   seg7_to_hex u_seg7_to_hex (
      .seg    (seg_q),
      .legal  (legal),
      .nibble (nibble)
   );

   // done marks the current visit as finished: accepted, ignored or aborted.
   always_comb begin
      onehot = 1'b0;
      idx    = '0;
      case (en_q)
         4'b0001: begin onehot = 1'b1; idx = 2'd0; end
         4'b0010: begin onehot = 1'b1; idx = 2'd1; end
         4'b0100: begin onehot = 1'b1; idx = 2'd2; end
         4'b1000: begin onehot = 1'b1; idx = 2'd3; end
         default: ;
      endcase
      multi      = !onehot && (en_q != '0);
      new_visit  = en_q != cur_en;
      track      = (state == SYNC) ? (idx == 2'd0) : (idx == expected);
      visit_fail = new_visit && (state == COLLECT) && (!done || !track);
      live       = onehot && !visit_fail && (new_visit ? track : !done);
      run        = (!new_visit && seg_q == last_seg) ? cnt + 4'd1 : 4'd1;
      fail       = multi || (onehot && visit_fail) || (live && !legal);
      accept     = live && legal && (run == STABLE_CNT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         seg_q    <= '0;
         en_q     <= '0;
         state    <= SYNC;
         expected <= '0;
         cnt      <= '0;
         last_seg <= '0;
         cur_en   <= '0;
         done     <= 1'b0;
         shadow   <= '0;
         value    <= '0;
         valid    <= 1'b0;
         err      <= 1'b0;
      end else begin
         seg_q <= seg;
         en_q  <= dig_en;
         valid <= 1'b0;
         err   <= 1'b0;
         if (multi || onehot)
            cur_en <= en_q;
         // Error and completion share one branch chain so err always wins.
         if (fail) begin
            err      <= 1'b1;
            state    <= SYNC;
            expected <= '0;
            done     <= 1'b1;
            cnt      <= '0;
            shadow   <= '0;
         end else if (live) begin
            last_seg <= seg_q;
            cnt      <= run;
            done     <= accept;
            if (accept) begin
               if (state == SYNC) begin
                  shadow[3:0] <= nibble;
                  expected    <= 2'd1;
                  state       <= COLLECT;
               end else begin
                  case (expected)
                     2'd1: begin shadow[7:4]  <= nibble; expected <= 2'd2; end
                     2'd2: begin shadow[11:8] <= nibble; expected <= 2'd3; end
                     2'd3: begin
                        value    <= {nibble, shadow};
                        valid    <= 1'b1;
                        state    <= SYNC;
                        expected <= '0;
                     end
                     default: ;
                  endcase
               end
            end
         end else if (onehot && new_visit) begin
            done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed and random visits checked against a visit-level behavioural
// model of the scanned-display protocol.
module tb_seg_scan_decoder;

   localparam int STABLE = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  seg;
   logic [3:0]  dig_en;
   logic [15:0] value;
   logic        valid;
   logic        err;

   int checks = 0;
   int errors = 0;
   int ecnt = 0;
   int vcnt = 0;

   logic [6:0] segs [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };
   logic [3:0] multis [6] = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100};

   // model state
   bit          m_in;
   bit          m_open;
   int          m_k;
   logic [3:0]  m_sh [4];
   logic [15:0] m_value;
   logic [6:0]  vpats [$];
   logic [3:0]  prev_code;

   always #5 clk = ~clk;

   seg_scan_decoder #(.STABLE(STABLE)) dut (
      .clk    (clk),
      .reset  (reset),
      .seg    (seg),
      .dig_en (dig_en),
      .value  (value),
      .valid  (valid),
      .err    (err)
   );

   always @(negedge clk) begin
      if (err === 1'b1) ecnt++;
      if (valid === 1'b1) vcnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [6:0] s, input logic [3:0] e);
      seg    = s;
      dig_en = e;
      @(posedge clk);
      #1;
   endtask

   function automatic int lookup(input logic [6:0] p);
      for (int i = 0; i < 16; i++)
         if (segs[i] == p) return i;
      return -1;
   endfunction

   function automatic logic [6:0] illegal_pat();
      logic [6:0] p;
      for (int t = 0; t < 1000; t++) begin
         p = 7'($urandom);
         if (lookup(p) < 0) return p;
      end
      return 7'b0000001;
   endfunction

   task automatic model_reset();
      m_in      = 1'b0;
      m_open    = 1'b0;
      m_k       = 0;
      m_value   = '0;
      prev_code = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(7'($urandom), 4'b0000);
      step(7'($urandom), 4'b0000);
      reset = 1'b0;
      model_reset();
   endtask

   // One visit of code holding vpats (blank cycles interleaved), then two
   // blank flush cycles; pulses and value are compared for the window.
   task automatic run_visit(input logic [3:0] code, input int bmin, input int bmax, input bit lat);
      int e0, v0, exp_err, exp_val, d, run, n, nib;
      bit acc, bad;
      e0 = ecnt; v0 = vcnt; exp_err = 0; exp_val = 0;
      d = (code == 4'b0001) ? 0 : (code == 4'b0010) ? 1 : (code == 4'b0100) ? 2 : 3;
      if ($countones(code) > 1) begin
         exp_err = vpats.size();
         m_in = 1'b0; m_open = 1'b0;
      end else if (m_in && (m_open || d != m_k)) begin
         exp_err = 1;
         m_in = 1'b0; m_open = 1'b0;
      end else if (!(m_in ? (d == m_k) : (d == 0))) begin
         m_open = 1'b0;
      end else begin
         run = 0; acc = 1'b0; bad = 1'b0; nib = 0;
         for (int i = 0; i < vpats.size(); i++) begin
            n = lookup(vpats[i]);
            if (n < 0) begin bad = 1'b1; break; end
            run = (i > 0 && vpats[i] == vpats[i-1]) ? run + 1 : 1;
            if (run == STABLE) begin acc = 1'b1; nib = n; break; end
         end
         if (bad) begin
            exp_err = 1;
            m_in = 1'b0; m_open = 1'b0;
         end else if (acc) begin
            m_open = 1'b0;
            if (!m_in) begin
               m_in = 1'b1; m_k = 1; m_sh[0] = 4'(nib);
            end else begin
               m_sh[m_k] = 4'(nib);
               if (m_k == 3) begin
                  m_value = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
                  exp_val = 1;
                  m_in = 1'b0;
               end else begin
                  m_k++;
               end
            end
         end else begin
            m_open = 1'b1;
         end
      end
      foreach (vpats[i]) begin
         repeat ($urandom_range(bmin, bmax)) step(7'($urandom), 4'b0000);
         step(vpats[i], code);
      end
      if (lat && exp_val == 1) begin
         chk("valid_before_latency", 32'(valid), 32'd0);
         step(7'($urandom), 4'b0000);
         chk("valid_at_latency", 32'(valid), 32'd1);
         chk("value_at_latency", 32'(value), 32'(m_value));
         step(7'($urandom), 4'b0000);
      end else begin
         step(7'($urandom), 4'b0000);
         step(7'($urandom), 4'b0000);
      end
      chk("err_pulses", ecnt - e0, exp_err);
      chk("valid_pulses", vcnt - v0, exp_val);
      chk("value", 32'(value), 32'(m_value));
      prev_code = code;
   endtask

   task automatic frame(input logic [15:0] v, input int bmin, input int bmax, input bit lat);
      for (int d = 0; d < 4; d++) begin
         vpats.delete();
         repeat (STABLE) vpats.push_back(segs[v[4*d +: 4]]);
         run_visit(4'(1 << d), bmin, bmax, lat && d == 3);
      end
   endtask

   initial begin
      int e0, v0, r, k, b;
      logic [3:0] code;
      logic [3:0] nibr;

      reset  = 1'b1;
      seg    = '0;
      dig_en = '0;
      step(7'h7F, 4'b1111);
      step(7'h7F, 4'b1111);
      chk("reset_value", 32'(value), 32'h0);
      chk("reset_valid", 32'(valid), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      reset = 1'b0;
      model_reset();

      // clean frame, exact latency on the last digit
      frame(16'h1A2F, 0, 0, 1'b1);
      chk("frame_1a2f", 32'(value), 32'h1A2F);

      // same frame with one blank cycle before every sample
      do_reset();
      e0 = ecnt;
      frame(16'h1A2F, 1, 1, 1'b0);
      chk("blank_frame_value", 32'(value), 32'h1A2F);
      chk("blank_frame_no_err", ecnt - e0, 0);

      // digit 2 never stable
      e0 = ecnt; v0 = vcnt;
      vpats = '{segs[15], segs[15]}; run_visit(4'b0001, 0, 0, 1'b0);
      vpats = '{segs[2], segs[2]};   run_visit(4'b0010, 0, 0, 1'b0);
      vpats = '{segs[10], segs[14]}; run_visit(4'b0100, 0, 0, 1'b0);
      vpats = '{segs[1], segs[1]};   run_visit(4'b1000, 0, 0, 1'b0);
      chk("unstable_err", ecnt - e0, 1);
      chk("unstable_no_valid", vcnt - v0, 0);
      chk("unstable_value_kept", 32'(value), 32'h1A2F);

      // illegal pattern, then a clean all-zero frame
      e0 = ecnt;
      vpats = '{segs[15], segs[15]}; run_visit(4'b0001, 0, 0, 1'b0);
      vpats = '{7'b0000001};         run_visit(4'b0010, 0, 0, 1'b0);
      chk("illegal_err", ecnt - e0, 1);
      frame(16'h0000, 0, 0, 1'b0);
      chk("zero_frame", 32'(value), 32'h0000);

      // multi-hot strobe, then out-of-order scan
      e0 = ecnt;
      vpats = '{segs[3], segs[3]}; run_visit(4'b0001, 0, 0, 1'b0);
      vpats = '{segs[4], segs[4]}; run_visit(4'b0010, 0, 0, 1'b0);
      vpats = '{segs[5]};          run_visit(4'b0101, 0, 0, 1'b0);
      vpats = '{segs[6], segs[6]}; run_visit(4'b0001, 0, 0, 1'b0);
      vpats = '{segs[7], segs[7]}; run_visit(4'b0100, 0, 0, 1'b0);
      chk("order_err", ecnt - e0, 2);
      chk("order_value_kept", 32'(value), 32'h0000);

      // reset mid-frame after digit 2
      frame(16'h5A5A, 0, 0, 1'b0);
      vpats = '{segs[4], segs[4]}; run_visit(4'b0001, 0, 0, 1'b0);
      vpats = '{segs[3], segs[3]}; run_visit(4'b0010, 0, 0, 1'b0);
      vpats = '{segs[2], segs[2]}; run_visit(4'b0100, 0, 0, 1'b0);
      e0 = ecnt; v0 = vcnt;
      do_reset();
      chk("midreset_no_err", ecnt - e0, 0);
      chk("midreset_no_valid", vcnt - v0, 0);
      chk("midreset_value", 32'(value), 32'h0000);
      frame(16'hBEEF, 0, 0, 1'b1);
      chk("frame_beef", 32'(value), 32'hBEEF);

      // random visits
      for (int v = 0; v < 250; v++) begin
         r = $urandom_range(0, 99);
         if (r < 4)       code = multis[$urandom_range(0, 5)];
         else if (r < 16) code = 4'(1 << $urandom_range(0, 3));
         else             code = 4'(1 << (m_in ? m_k : 0));
         if (code == prev_code) code = {code[2:0], code[3]};
         vpats.delete();
         k = $urandom_range(0, 99);
         if (k < 8) begin
            vpats.push_back(segs[$urandom_range(0, 15)]);
         end else begin
            repeat ($urandom_range(0, 2)) vpats.push_back(segs[$urandom_range(0, 15)]);
            nibr = 4'($urandom_range(0, 15));
            repeat (STABLE) vpats.push_back(segs[nibr]);
            repeat ($urandom_range(0, 2)) vpats.push_back(7'($urandom));
         end
         if (k >= 92) vpats[$urandom_range(0, vpats.size() - 1)] = illegal_pat();
         b = $urandom_range(0, 2);
         run_visit(code, 0, b, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
